// File: rtl/tx_ffe_bdrate_if.sv
// Bus between the TX data source / coefficient host and the FFE, and from the FFE to the DAC driver.
// Handshake: valid-only, no backpressure. din is consumed on every clock edge where din_valid=1, and
// dac_out is meaningful on every edge where dout_valid=1. Coefficient strobes are single-cycle pulses.
interface tx_ffe_bdrate_if #(
    parameter int Nti   = 4,
    parameter int Npre  = 1,
    parameter int Npost = 1,
    parameter int Ncoef = 8,
    parameter int Ndac  = 8
);
    localparam int Ntap = Npre + Npost + 1;
    localparam int Niw  = (Ntap > 1) ? $clog2(Ntap) : 1;

    logic [Nti-1:0]          din;
    logic                    din_valid;
    logic                    bypass;
    logic                    coef_wr;
    logic [Niw-1:0]          coef_idx;
    logic signed [Ncoef-1:0] coef_data;
    logic                    coef_apply;
    logic signed [Ndac-1:0]  dac_out [Nti-1:0];
    logic                    dout_valid;

    modport master (
        output din, din_valid, bypass, coef_wr, coef_idx, coef_data, coef_apply,
        input  dac_out, dout_valid
    );

    modport slave (
        input  din, din_valid, bypass, coef_wr, coef_idx, coef_data, coef_apply,
        output dac_out, dout_valid
    );
endinterface

// File: rtl/tx_ffe_bdrate.sv
// Block-rate TX FFE: Nti bits per clock mapped to +/-1 symbols and filtered by pre/main/post taps.
// Optional TX_FFE_PRBS_EN adds an internal PRBS7 source selectable in place of din.
module tx_ffe_bdrate #(
    parameter int Nti      = 4,
    parameter int Npre     = 1,
    parameter int Npost    = 1,
    parameter int Ncoef    = 8,
    parameter int Ndac     = 8,
    parameter int MAIN_RST = 64
) (
    input  logic clk,
    input  logic rst,
`ifdef TX_FFE_PRBS_EN
    input  logic       prbs_sel,
    input  logic [6:0] prbs_seed,
`endif
    tx_ffe_bdrate_if.slave bus
);
    localparam int Ntap = Npre + Npost + 1;
    localparam int Niw  = (Ntap > 1) ? $clog2(Ntap) : 1;
    localparam int Nsum = Ncoef + 2 + $clog2(Ntap);
    localparam int Nacc = (Nsum > Ndac) ? Nsum : Ndac + 1;
    localparam int Nstr = Npost + Nti + Npre;
    localparam int Nhw  = (Npost > 0) ? Npost : 1;

    localparam logic signed [Nacc-1:0]  SAT_HI = Nacc'((2 ** (Ndac - 1)) - 1);
    localparam logic signed [Nacc-1:0]  SAT_LO = ~SAT_HI;
    localparam logic signed [Ncoef-1:0] MAIN_C = Ncoef'(MAIN_RST);
    localparam logic signed [Ndac-1:0]  BYP_P  = Ndac'(MAIN_RST);
    localparam logic signed [Ndac-1:0]  BYP_N  = -BYP_P;

    logic [Nti-1:0]          din_sel;
    logic [Nti-1:0]          fut_blk;
    logic [Nti-1:0]          cur_blk;
    logic [Nhw-1:0]          hist;
    logic [Nhw-1:0]          hist_nxt;
    logic                    fut_full;
    logic                    cur_full;
    logic                    emit;
    logic [Nstr-1:0]         strm;
    logic signed [Ncoef-1:0] shadow [Ntap];
    logic signed [Ncoef-1:0] active [Ntap];
    logic signed [Nacc-1:0]  psum   [Nti][Ntap+1];
    logic signed [Ndac-1:0]  dac_nxt [Nti];

    function automatic logic signed [Ndac-1:0] sat_code(input logic signed [Nacc-1:0] a);
        if (a > SAT_HI)      sat_code = SAT_HI[Ndac-1:0];
        else if (a < SAT_LO) sat_code = SAT_LO[Ndac-1:0];
        else                 sat_code = a[Ndac-1:0];
    endfunction

`ifdef TX_FFE_PRBS_EN
    // PRBS7 x^7+x^6+1, Nti steps unrolled per clock; slice 0 takes the first new bit.
    logic [6:0]     lfsr;
    logic [6:0]     lfsr_chain [Nti+1];
    logic [Nti-1:0] prbs_bits;

    assign lfsr_chain[0] = lfsr;
    for (genvar k = 0; k < Nti; k++) begin : g_prbs
        assign prbs_bits[k]      = lfsr_chain[k][6] ^ lfsr_chain[k][5];
        assign lfsr_chain[k + 1] = {lfsr_chain[k][5:0], prbs_bits[k]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= (prbs_seed == 7'd0) ? 7'h7F : prbs_seed;
        end else if (bus.din_valid && prbs_sel) begin
            lfsr <= lfsr_chain[Nti];
        end
    end

    assign din_sel = prbs_sel ? prbs_bits : bus.din;
`else
    assign din_sel = bus.din;
`endif

    // Oldest-first tail of the block that is leaving the "current" slot.
    if (Npost > 0) begin : g_hist_nxt
        assign hist_nxt = cur_blk[Nti-1 -: Npost];
    end else begin : g_no_hist
        assign hist_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fut_blk  <= '0;
            cur_blk  <= '0;
            hist     <= '0;
            fut_full <= 1'b0;
            cur_full <= 1'b0;
        end else if (bus.din_valid) begin
            fut_blk  <= din_sel;
            cur_blk  <= fut_blk;
            hist     <= hist_nxt;
            fut_full <= 1'b1;
            cur_full <= fut_full;
        end
    end

    // Symbol stream: {next-block pre symbols, current block, post history}, bit 0 oldest.
    assign strm[Npost +: Nti] = cur_blk;
    if (Npost > 0) begin : g_strm_post
        assign strm[Npost-1:0] = hist;
    end
    if (Npre > 0) begin : g_strm_pre
        assign strm[Npost+Nti +: Npre] = fut_blk[Npre-1:0];
    end

    for (genvar j = 0; j < Ntap; j++) begin : g_coef
        localparam logic signed [Ncoef-1:0] RST_C = (j == Npre) ? MAIN_C : '0;

        // Apply reads shadow before this edge's write, so a same-cycle write stays shadow-only.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shadow[j] <= RST_C;
                active[j] <= RST_C;
            end else begin
                if (bus.coef_apply) begin
                    active[j] <= shadow[j];
                end
                if (bus.coef_wr && (bus.coef_idx == Niw'(j))) begin
                    shadow[j] <= bus.coef_data;
                end
            end
        end
    end

    // Tap j multiplies the symbol at time offset (Npre - j) relative to slice k.
    for (genvar k = 0; k < Nti; k++) begin : g_slice
        assign psum[k][0] = '0;
        for (genvar j = 0; j < Ntap; j++) begin : g_tap
            logic signed [Nacc-1:0] cext;
            assign cext = $signed({{(Nacc - Ncoef){active[j][Ncoef-1]}}, active[j]});
            assign psum[k][j + 1] = strm[Npost + k + Npre - j] ? (psum[k][j] + cext)
                                                               : (psum[k][j] - cext);
        end

        assign dac_nxt[k] = bus.bypass ? (strm[Npost + k] ? BYP_P : BYP_N)
                                       : sat_code(psum[k][Ntap]);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                bus.dac_out[k] <= '0;
            end else if (emit) begin
                bus.dac_out[k] <= dac_nxt[k];
            end
        end
    end

    // A block is emitted only when the following block arrives, so it is known for the pre-cursor.
    assign emit = bus.din_valid & cur_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dout_valid <= 1'b0;
        end else begin
            bus.dout_valid <= emit;
        end
    end
endmodule

// File: tb/tb_tx_ffe_bdrate.sv
// Directed bench for tx_ffe_bdrate: time-indexed reference model feeds an expected queue,
// a negedge monitor pops and compares; hand-computed codes are checked at settled points.
module tb_tx_ffe_bdrate;
    localparam int Nti   = 4;
    localparam int Npre  = 1;
    localparam int Npost = 1;
    localparam int Ncoef = 8;
    localparam int Ndac  = 8;
    localparam int W     = Nti * Ndac;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tx_ffe_bdrate_if #(.Nti(Nti), .Npre(Npre), .Npost(Npost), .Ncoef(Ncoef), .Ndac(Ndac)) bus ();

    tx_ffe_bdrate #(
        .Nti(Nti), .Npre(Npre), .Npost(Npost), .Ncoef(Ncoef), .Ndac(Ndac), .MAIN_RST(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int             total = 0;
    int             bad   = 0;
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   last_exp = '0;
    logic [W-1:0]   mon_e;
    logic [Nti-1:0] blocks[$];
    int             m_active[3];
    int             m_shadow[3];

    function automatic logic [W-1:0] dac_packed();
        return {bus.dac_out[3], bus.dac_out[2], bus.dac_out[1], bus.dac_out[0]};
    endfunction

    // Symbol at absolute time t since reset; everything before the first block is -1.
    function automatic int sym(input int t);
        logic [Nti-1:0] b;
        if (t < 0) return -1;
        b = blocks[t / Nti];
        return b[t % Nti] ? 1 : -1;
    endfunction

    function automatic logic [W-1:0] model_blk(input int m, input logic byp);
        logic [W-1:0] r;
        int acc;
        r = '0;
        for (int k = 0; k < Nti; k++) begin
            if (byp) begin
                acc = (sym(m * Nti + k) > 0) ? 64 : -64;
            end else begin
                acc = 0;
                for (int j = 0; j < 3; j++) acc += m_active[j] * sym(m * Nti + k + 1 - j);
                if (acc > 127) acc = 127;
                if (acc < -128) acc = -128;
            end
            r[k * Ndac +: Ndac] = 8'(acc);
        end
        return r;
    endfunction

    task automatic model_reset();
        blocks.delete();
        exp_q.delete();
        m_active = '{0, 64, 0};
        m_shadow = '{0, 64, 0};
    endtask

    // Called at the active edge with the inputs that were just sampled.
    task automatic model_edge();
        if (bus.din_valid) begin
            blocks.push_back(bus.din);
            if (blocks.size() >= 3) exp_q.push_back(model_blk(blocks.size() - 3, bus.bypass));
        end
        if (bus.coef_apply) m_active = m_shadow;
        if (bus.coef_wr && (int'(bus.coef_idx) < 3)) m_shadow[bus.coef_idx] = int'(bus.coef_data);
    endtask

    task automatic step(input logic [Nti-1:0] d, input logic v);
        bus.din       = d;
        bus.din_valid = v;
        @(posedge clk);
        model_edge();
        #1;
        bus.coef_wr    = 1'b0;
        bus.coef_apply = 1'b0;
    endtask

    task automatic wr(input logic [1:0] idx, input logic signed [Ncoef-1:0] d);
        bus.coef_wr   = 1'b1;
        bus.coef_idx  = idx;
        bus.coef_data = d;
    endtask

    task automatic apply();
        bus.coef_apply = 1'b1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.dout_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got %h want none", dac_packed());
            end else begin
                mon_e    = exp_q.pop_front();
                last_exp = mon_e;
                if (dac_packed() !== mon_e) begin
                    bad++;
                    $display("FAIL sb_data: got %h want %h", dac_packed(), mon_e);
                end
            end
        end
    end

    initial begin
        logic [Nti-1:0] gap_pre [4]  = '{4'b0011, 4'b1001, 4'b0111, 4'b1100};
        logic [Nti-1:0] gap_post [6] = '{4'b1010, 4'b0001, 4'b1110, 4'b0100, 4'b0110, 4'b1011};

        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.bypass     = 1'b0;
        bus.coef_wr    = 1'b0;
        bus.coef_idx   = '0;
        bus.coef_data  = '0;
        bus.coef_apply = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", W'(bus.dout_valid), W'(0));
        chk("reset_dac", dac_packed(), W'(0));
        @(negedge clk);
        rst = 1'b0;

        step(4'b1111, 1'b1);
        chk("lat_edge0", W'(bus.dout_valid), W'(0));
        step(4'b1111, 1'b1);
        chk("lat_edge1", W'(bus.dout_valid), W'(0));
        step(4'b1111, 1'b1);
        chk("lat_edge2", W'(bus.dout_valid), W'(1));
        chk("ones_main64", dac_packed(), 32'h40404040);

        wr(2'd1, 8'sd32);
        apply();
        step(4'b1111, 1'b1);
        chk("wr_apply_same", dac_packed(), 32'h40404040);
        repeat (3) step(4'b1111, 1'b1);
        chk("main_stays_64", dac_packed(), 32'h40404040);
        apply();
        step(4'b1111, 1'b1);
        chk("apply_edge_old", dac_packed(), 32'h40404040);
        step(4'b1111, 1'b1);
        chk("apply_new_32", dac_packed(), 32'h20202020);

        wr(2'd3, 8'sd5);
        step(4'b1111, 1'b1);
        apply();
        repeat (3) step(4'b1111, 1'b1);
        chk("idx_out_of_range", dac_packed(), 32'h20202020);

        wr(2'd0, -8'sd8);
        step(4'b1111, 1'b1);
        wr(2'd2, -8'sd16);
        step(4'b1111, 1'b1);
        wr(2'd1, 8'sd64);
        step(4'b1111, 1'b1);
        apply();
        step(4'b1111, 1'b1);
        repeat (4) step(4'b0101, 1'b1);
        chk("deemph_0101", dac_packed(), 32'hA858A858);

        wr(2'd0, -8'sd127);
        step(4'b0101, 1'b1);
        wr(2'd1, 8'sd127);
        step(4'b0101, 1'b1);
        wr(2'd2, -8'sd127);
        step(4'b0101, 1'b1);
        apply();
        step(4'b0101, 1'b1);
        repeat (4) step(4'b0101, 1'b1);
        chk("sat_0101", dac_packed(), 32'h807F807F);
        repeat (4) step(4'b1010, 1'b1);
        chk("sat_1010", dac_packed(), 32'h7F807F80);

        bus.bypass = 1'b1;
        repeat (4) step(4'b0110, 1'b1);
        chk("bypass_0110", dac_packed(), 32'hC04040C0);
        bus.bypass = 1'b0;

        foreach (gap_pre[i]) step(gap_pre[i], 1'b1);
        for (int g = 0; g < 3; g++) begin
            step(4'b1111, 1'b0);
            chk("gap_valid_low", W'(bus.dout_valid), W'(0));
            chk("gap_dac_hold", dac_packed(), last_exp);
        end
        foreach (gap_post[i]) step(gap_post[i], 1'b1);

        step(4'b0101, 1'b1);
        chk("pre_rst_valid", W'(bus.dout_valid), W'(1));
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", W'(bus.dout_valid), W'(0));
        chk("rst_mid_dac", dac_packed(), W'(0));
        model_reset();
        bus.din_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        repeat (3) step(4'b1111, 1'b1);
        chk("post_rst_valid", W'(bus.dout_valid), W'(1));
        chk("post_rst_main64", dac_packed(), 32'h40404040);
        repeat (4) step(4'b0101, 1'b1);
        chk("post_rst_taps0", dac_packed(), 32'hC040C040);

        repeat (2) step(4'b0000, 1'b0);
        chk("sb_drained", W'(exp_q.size()), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
